// File: rtl/npc_seq.sv
// Next-PC sequencer: control-flow decode, one-instruction delay slot, jal link.
// Define NPC_BOUND_CHECK_EN to clamp out-of-range npc values to PC_BASE.
module npc_seq #(
   parameter logic [31:0] PC_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        rs_eq,
   input  logic [31:0] rs_val,
   input  logic        stall,
   output logic [31:0] npc,
   output logic [31:0] link_addr,
   output logic        link_we,
   output logic        slot,
   output logic        err
);

   typedef enum logic {SEQ, SLOT} state_e;

   localparam logic [32:0] PC_END = {1'b0, PC_BASE} + 33'(IM_WORDS) * 33'd4;

   state_e      state_q, state_d;
   logic [31:0] tgt_q, tgt_d;
   logic        err_q, err_d;

   logic [5:0]  op;
   logic        is_beq, is_bne, is_j, is_jal, is_jr;
   logic        is_ctrl, taken;
   logic [31:0] pc4, pc8, br_off, target;
   logic [31:0] npc_raw;
   logic        oob;

   assign op     = instr[31:26];
   assign is_beq = (op == 6'b000100);
   assign is_bne = (op == 6'b000101);
   assign is_j   = (op == 6'b000010);
   assign is_jal = (op == 6'b000011);
   assign is_jr  = (op == 6'b000000) && (instr[5:0] == 6'b001000);

   assign is_ctrl = is_beq | is_bne | is_j | is_jal | is_jr;
   assign pc4     = pc + 32'd4;
   assign pc8     = pc + 32'd8;
   assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = pc4;
      unique case (1'b1)
         is_beq: begin
            taken  = rs_eq;
            target = pc4 + br_off;
         end
         is_bne: begin
            taken  = ~rs_eq;
            target = pc4 + br_off;
         end
         is_j, is_jal: begin
            taken  = 1'b1;
            target = {pc4[31:28], instr[25:0], 2'b00};
         end
         is_jr: begin
            taken  = 1'b1;
            target = {rs_val[31:2], 2'b00};
         end
         default: begin
            taken  = 1'b0;
            target = pc4;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      err_d   = err_q;
      npc_raw = pc;
      npc     = pc;
      oob     = 1'b0;
      if (reset) begin
         state_d = SEQ;
         tgt_d   = PC_BASE;
         err_d   = 1'b0;
         npc_raw = PC_BASE;
         npc     = PC_BASE;
      end else if (!stall) begin
         if (state_q == SLOT) begin
            npc_raw = tgt_q;
            state_d = SEQ;
            // a control instr sitting in the delay slot never redirects
            if (is_ctrl) err_d = 1'b1;
         end else begin
            npc_raw = pc4;
            if (is_ctrl && taken) begin
               tgt_d   = target;
               state_d = SLOT;
               if (is_jr && (rs_val[1:0] != 2'b00)) err_d = 1'b1;
            end
         end
         npc = npc_raw;
         oob = ({1'b0, npc_raw} < {1'b0, PC_BASE}) ||
               ({1'b0, npc_raw} >= PC_END);
`ifdef NPC_BOUND_CHECK_EN
         if (oob) begin
            err_d   = 1'b1;
            npc     = PC_BASE;
            state_d = SEQ;
         end
`endif
      end
   end

`ifndef NPC_BOUND_CHECK_EN
   logic unused_oob;
   assign unused_oob = oob;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEQ;
         tgt_q   <= PC_BASE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         err_q   <= err_d;
      end
   end

   assign link_addr = (!reset && is_jal) ? pc8 : 32'd0;
   assign link_we   = !reset && is_jal && !stall;
   assign slot      = !reset && (state_q == SLOT);
   assign err       = err_q;

endmodule

// File: tb/tb_npc_seq.sv
// Directed self-checking bench for npc_seq.
// Expected values are hand-derived from the MIPS delay-slot rules.
module tb_npc_seq;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        rs_eq;
   logic [31:0] rs_val;
   logic        stall;
   logic [31:0] npc;
   logic [31:0] link_addr;
   logic        link_we;
   logic        slot;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   npc_seq dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .instr     (instr),
      .rs_eq     (rs_eq),
      .rs_val    (rs_val),
      .stall     (stall),
      .npc       (npc),
      .link_addr (link_addr),
      .link_we   (link_we),
      .slot      (slot),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] BEQ4  = 32'h1000_0004;
   localparam logic [31:0] BNE4  = 32'h1400_0004;
   localparam logic [31:0] JAL   = 32'h0C00_0C10;
   localparam logic [31:0] J3080 = 32'h0800_0C20;
   localparam logic [31:0] J3000 = 32'h0800_0C00;
   localparam logic [31:0] JR    = 32'h0000_0008;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] p, input logic [31:0] i);
      pc    = p;
      instr = i;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      stall  = 1'b0;
      rs_eq  = 1'b0;
      rs_val = 32'd0;
      drive(32'h3000, NOP);
      step();
      chk("rst_npc", npc, 32'h3000);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_slot", {31'd0, slot}, 32'd0);
      drive(32'h3000, JAL);
      chk("rst_link", link_addr, 32'd0);
      chk("rst_lwe", {31'd0, link_we}, 32'd0);
      stall = 1'b1;
      chk("rst_stall_npc", npc, 32'h3000);
      stall = 1'b0;

      // sequential fetch
      reset = 1'b0;
      drive(32'h3000, NOP);
      chk("seq0", npc, 32'h3004);
      step();
      drive(32'h3004, NOP);
      chk("seq1", npc, 32'h3008);
      step();

      // beq taken: branch, slot, target
      rs_eq = 1'b1;
      drive(32'h3010, BEQ4);
      chk("beq_t_npc", npc, 32'h3014);
      chk("beq_t_slot", {31'd0, slot}, 32'd0);
      step();
      drive(32'h3014, NOP);
      chk("beq_t_tgt", npc, 32'h3024);
      chk("beq_t_slot1", {31'd0, slot}, 32'd1);
      step();
      drive(32'h3024, NOP);
      chk("beq_t_back", npc, 32'h3028);
      chk("beq_t_slot2", {31'd0, slot}, 32'd0);
      step();

      // beq not taken
      rs_eq = 1'b0;
      drive(32'h3010, BEQ4);
      chk("beq_nt_npc", npc, 32'h3014);
      step();
      drive(32'h3014, NOP);
      chk("beq_nt_next", npc, 32'h3018);
      chk("beq_nt_slot", {31'd0, slot}, 32'd0);
      step();

      // bne taken on rs_eq=0
      drive(32'h3020, BNE4);
      chk("bne_npc", npc, 32'h3024);
      step();
      drive(32'h3024, NOP);
      chk("bne_tgt", npc, 32'h3034);
      chk("bne_slot", {31'd0, slot}, 32'd1);
      step();

      // jal stalled: no link write, no redirect
      stall = 1'b1;
      drive(32'h3000, JAL);
      chk("jal_st_npc", npc, 32'h3000);
      chk("jal_st_link", link_addr, 32'h3008);
      chk("jal_st_lwe", {31'd0, link_we}, 32'd0);
      step();
      chk("jal_st_slot", {31'd0, slot}, 32'd0);
      stall = 1'b0;
      drive(32'h3000, JAL);
      chk("jal_npc", npc, 32'h3004);
      chk("jal_link", link_addr, 32'h3008);
      chk("jal_lwe", {31'd0, link_we}, 32'd1);
      step();
      drive(32'h3004, NOP);
      chk("jal_tgt", npc, 32'h3040);
      chk("jal_nolink", link_addr, 32'd0);
      step();

      // j with 3-cycle stall in SLOT
      drive(32'h3040, J3080);
      chk("j_npc", npc, 32'h3044);
      step();
      stall = 1'b1;
      drive(32'h3044, NOP);
      for (int k = 0; k < 3; k++) begin
         chk("j_stall_npc", npc, 32'h3044);
         chk("j_stall_slot", {31'd0, slot}, 32'd1);
         step();
      end
      stall = 1'b0;
      #1;
      chk("j_release", npc, 32'h3080);
      step();
      chk("j_slot_clr", {31'd0, slot}, 32'd0);

      // control instr in delay slot
      drive(32'h3080, J3000);
      chk("ds_npc", npc, 32'h3084);
      chk("ds_err0", {31'd0, err}, 32'd0);
      step();
      rs_eq = 1'b1;
      drive(32'h3084, BEQ4);
      chk("ds_tgt", npc, 32'h3000);
      step();
      rs_eq = 1'b0;
      chk("ds_err1", {31'd0, err}, 32'd1);
      chk("ds_noslot", {31'd0, slot}, 32'd0);
      drive(32'h3000, NOP);
      chk("ds_after", npc, 32'h3004);

      // reset clears err and drops a pending redirect
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst2_err", {31'd0, err}, 32'd0);
      drive(32'h3000, J3080);
      step();
      chk("rs_slot_pre", {31'd0, slot}, 32'd1);
      reset = 1'b1;
      stall = 1'b1;
      drive(32'h3004, NOP);
      chk("rs_slot_npc", npc, 32'h3000);
      chk("rs_slot_slot", {31'd0, slot}, 32'd0);
      step();
      reset = 1'b0;
      stall = 1'b0;
      drive(32'h3000, NOP);
      chk("rs_lost", npc, 32'h3004);
      chk("rs_lost_slot", {31'd0, slot}, 32'd0);
      step();

      // misaligned jr
      rs_val = 32'h0000_3102;
      drive(32'h3040, JR);
      chk("jr_npc", npc, 32'h3044);
      chk("jr_err0", {31'd0, err}, 32'd0);
      step();
      drive(32'h3044, NOP);
      chk("jr_err1", {31'd0, err}, 32'd1);
      chk("jr_tgt", npc, 32'h3100);
      step();

      // jr beyond instruction memory
      reset = 1'b1;
      step();
      reset = 1'b0;
      rs_val = 32'h0000_7000;
      drive(32'h3040, JR);
      chk("oob_npc", npc, 32'h3044);
      step();
      drive(32'h3044, NOP);
`ifdef NPC_BOUND_CHECK_EN
      chk("oob_clamp", npc, 32'h3000);
      step();
      chk("oob_err", {31'd0, err}, 32'd1);
      chk("oob_slot", {31'd0, slot}, 32'd0);
`else
      chk("oob_pass", npc, 32'h7000);
      step();
      chk("oob_err", {31'd0, err}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
